// File: rtl/ram_uart_streamer_pkg.sv
// Shared definitions for the loopback RAM read path: streamer state encoding
// and the default bus widths used by ctrl, ram and uart_byte_tx.
package ram_uart_streamer_pkg;

    localparam int DEF_ADDR_W = 13;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_RD_LAT = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_WAIT_TX = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/ram_uart_streamer.sv
// Streams a length-bounded block of bytes from the RAM read port into
// uart_byte_tx, one byte per send_en/tx_done round trip, with abort support.
//
// Handshake: send_en is a single-cycle request that hands tx_data to the
// transmitter; tx_data stays stable until the next LOAD. Exactly one send_en
// is issued per accepted tx_done, and tx_done is only honoured in WAIT_TX.
// abort outranks tx_done and start in the same cycle and suppresses send_en
// and done in that cycle; the byte already on the line is left to finish.
module ram_uart_streamer
    import ram_uart_streamer_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   byte_cnt,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              send_en,
    input  logic              tx_done,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [2:0]        state
);

    // FETCH lasts RD_LAT+1 cycles: RD_LAT for the RAM pipeline to present the
    // byte, plus the cycle in which it is captured into tx_data on entry to LOAD.
    localparam int                WAIT_W    = $clog2(RD_LAT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT);
    localparam logic [ADDR_W:0]   REM_ONE   = (ADDR_W + 1)'(1);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W:0]   remaining;
    logic [WAIT_W-1:0] wait_cnt;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort returns to IDLE from every active state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (byte_cnt != '0) ? ST_FETCH : ST_DONE;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = abort ? ST_IDLE : ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tx_done) begin
                    state_d = (remaining <= REM_ONE) ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Combinational outputs decoded from the current state
    always_comb begin
        busy    = (state_q != ST_IDLE);
        send_en = (state_q == ST_LOAD) && !abort;
        state   = state_q;
    end

    // Datapath: address/length tracking, byte capture and the status pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr   <= '0;
            tx_data   <= '0;
            remaining <= '0;
            wait_cnt  <= '0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            done     <= 1'b0;
            aborted  <= abort && (state_q != ST_IDLE);
            wait_cnt <= (state_q == ST_FETCH) ? wait_cnt + WAIT_W'(1) : '0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        remaining <= byte_cnt;
                        if (byte_cnt != '0) begin
                            rd_addr <= start_addr;
                        end
                    end
                end
                ST_FETCH: begin
                    if (!abort && wait_cnt == WAIT_LAST) begin
                        tx_data <= rd_data;
                    end
                end
                ST_WAIT_TX: begin
                    if (!abort && tx_done && remaining != '0) begin
                        remaining <= remaining - REM_ONE;
                        if (remaining != REM_ONE) begin
                            rd_addr <= rd_addr + ADDR_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    done <= !abort;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_uart_streamer.sv
// Bench for ram_uart_streamer: RAM model with two-cycle read latency holding
// addr[7:0]^A5, and a transmitter model pulsing tx_done a set delay after send_en.
module tb_ram_uart_streamer;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   byte_cnt;
    logic              abort;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] tx_data;
    logic              send_en;
    logic              tx_done;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [2:0]        state;

    logic model_done;
    logic manual_done;
    assign tx_done = model_done | manual_done;

    ram_uart_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .start_addr (start_addr),
        .byte_cnt   (byte_cnt),
        .abort      (abort),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .tx_data    (tx_data),
        .send_en    (send_en),
        .tx_done    (tx_done),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .state      (state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // ---------------- models ----------------
    function automatic logic [7:0] ram_byte(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    logic [ADDR_W-1:0] ram_addr_q;
    always @(posedge clk) begin
        ram_addr_q <= rd_addr;
        rd_data    <= ram_byte(ram_addr_q);
    end

    int tx_delay   = 20;
    bit tx_auto    = 1'b1;
    bit tx_pending = 1'b0;
    int tx_timer   = 0;

    always @(posedge clk) begin
        #1;
        model_done = 1'b0;
        if (tx_pending) begin
            tx_timer = tx_timer - 1;
            if (tx_timer <= 0) begin
                model_done = 1'b1;
                tx_pending = 1'b0;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [DATA_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    int send_cycs[$];
    int txd_cycs[$];

    int errors = 0;
    int checks = 0;
    int sent = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int abort_cnt = 0;
    int abort_seen_cyc = 0;
    int busy_cyc = 0;
    int start_cyc = 0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (busy) busy_cyc = busy_cyc + 1;
            if (send_en) begin
                sent = sent + 1;
                send_cycs.push_back(cyc);
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL send_en_extra: got send_en with tx_data=%h, required no send_en", tx_data);
                end else begin
                    logic [DATA_W-1:0] eb;
                    logic [ADDR_W-1:0] ea;
                    eb = exp_q.pop_front();
                    ea = exp_addr_q.pop_front();
                    if (tx_data !== eb) begin
                        errors = errors + 1;
                        $display("FAIL tx_data: got %h required %h", tx_data, eb);
                    end
                    checks = checks + 1;
                    if (rd_addr !== ea) begin
                        errors = errors + 1;
                        $display("FAIL rd_addr: got %h required %h", rd_addr, ea);
                    end
                end
                if (tx_auto) begin
                    tx_pending = 1'b1;
                    tx_timer   = tx_delay;
                end
            end
            if (tx_done) txd_cycs.push_back(cyc);
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
            if (aborted) begin
                abort_cnt = abort_cnt + 1;
                abort_seen_cyc = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_stats();
        sent = 0;
        done_cnt = 0;
        abort_cnt = 0;
        busy_cyc = 0;
        send_cycs.delete();
        txd_cycs.delete();
        exp_q.delete();
        exp_addr_q.delete();
    endtask

    task automatic start_stream(input logic [ADDR_W-1:0] a, input int n);
        @(posedge clk); #1;
        start      = 1'b1;
        start_addr = a;
        byte_cnt   = n[ADDR_W:0];
        start_cyc  = cyc;
        for (int i = 0; i < n; i++) begin
            logic [ADDR_W-1:0] ai;
            ai = a + i[ADDR_W-1:0];
            exp_q.push_back(ram_byte(ai));
            exp_addr_q.push_back(ai);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_done(input logic with_abort, output int ev_cyc);
        @(posedge clk); #1;
        manual_done = 1'b1;
        abort       = with_abort;
        ev_cyc      = cyc;
        @(posedge clk); #1;
        manual_done = 1'b0;
        abort       = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        int d0;
        n = 0;
        d0 = done_cnt;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks = checks + 1;
        if (done_cnt == d0) begin
            errors = errors + 1;
            $display("FAIL %s_timeout: got no done in %0d cycles, required done", name, budget);
        end
    endtask

    task automatic wait_sent(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (sent < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks = checks + 1;
        if (sent < target) begin
            errors = errors + 1;
            $display("FAIL %s_timeout: got %0d send_en, required %0d", name, sent, target);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b0; start_addr = '0; byte_cnt = '0; abort = 1'b0;
        manual_done = 1'b0; model_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks = checks + 1;
        if ({rd_addr, tx_data, send_en, busy, done, aborted, state} !== '0) begin
            errors = errors + 1;
            $display("FAIL reset_values: got rd_addr=%h tx_data=%h send_en=%b busy=%b done=%b aborted=%b state=%0d, required all 0",
                     rd_addr, tx_data, send_en, busy, done, aborted, state);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        clear_stats();
        tx_delay = 20; tx_auto = 1'b1;
        start_stream(13'h0000, 4);
        wait_done("basic", 400);
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (sent != 4) begin errors++; $display("FAIL basic_count: got %0d send_en, required 4", sent); end
        checks = checks + 1;
        if (send_cycs.size() < 1 || send_cycs[0] - start_cyc != RD_LAT + 2) begin
            errors++;
            $display("FAIL basic_first_latency: got %0d cycles, required %0d",
                     send_cycs.size() > 0 ? send_cycs[0] - start_cyc : -1, RD_LAT + 2);
        end
        checks = checks + 1;
        if (send_cycs.size() < 2 || txd_cycs.size() < 1 || send_cycs[1] - txd_cycs[0] != RD_LAT + 2) begin
            errors++;
            $display("FAIL basic_txdone_latency: got wrong tx_done to send_en gap, required %0d", RD_LAT + 2);
        end
        checks = checks + 1;
        if (done_cnt != 1) begin errors++; $display("FAIL basic_done_count: got %0d, required 1", done_cnt); end
        checks = checks + 1;
        if (txd_cycs.size() != 4 || done_cyc != txd_cycs[txd_cycs.size()-1] + 2) begin
            errors++;
            $display("FAIL basic_done_timing: got done at cycle %0d after %0d tx_done, required 2 cycles after 4th", done_cyc, txd_cycs.size());
        end
    endtask

    task automatic test_wrap();
        clear_stats();
        tx_delay = 6; tx_auto = 1'b1;
        start_stream(13'h1FFE, 4);
        wait_done("wrap", 300);
        checks = checks + 1;
        if (sent != 4 || exp_q.size() != 0) begin
            errors++; $display("FAIL wrap_count: got %0d send_en, required 4", sent);
        end
    endtask

    task automatic test_zero_len();
        clear_stats();
        start_stream(13'h0010, 0);
        wait_done("zero", 20);
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (done_cyc - start_cyc != 2) begin errors++; $display("FAIL zero_done_timing: got %0d cycles, required 2", done_cyc - start_cyc); end
        checks = checks + 1;
        if (busy_cyc != 1) begin errors++; $display("FAIL zero_busy_cycles: got %0d, required 1", busy_cyc); end
        checks = checks + 1;
        if (sent != 0 || done_cnt != 1) begin errors++; $display("FAIL zero_counts: got sent=%0d done=%0d, required 0 and 1", sent, done_cnt); end
    endtask

    task automatic test_abort();
        int ev;
        int abort_cyc;
        clear_stats();
        tx_auto = 1'b0;
        start_stream(13'h0020, 5);
        wait_sent("abort_first", 1, 20);
        pulse_done(1'b0, ev);
        wait_sent("abort_second", 2, 20);
        pulse_done(1'b1, abort_cyc);
        checks = checks + 1;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy=%b, required 0", busy); end
        exp_q.delete();
        exp_addr_q.delete();
        tx_auto = 1'b1; tx_delay = 5;
        start_stream(13'h0030, 1);
        wait_done("abort_restart", 100);
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (abort_cnt != 1 || abort_seen_cyc != abort_cyc + 1) begin
            errors++; $display("FAIL abort_pulse: got %0d pulses at cycle %0d, required 1 at %0d", abort_cnt, abort_seen_cyc, abort_cyc + 1);
        end
        checks = checks + 1;
        if (send_cycs.size() != 3 || send_cycs[2] - start_cyc != RD_LAT + 2 || start_cyc != abort_cyc + 2) begin
            errors++; $display("FAIL abort_restart: got %0d send_en total, required 2 plus 1 restarted", send_cycs.size());
        end
        checks = checks + 1;
        if (done_cnt != 1) begin errors++; $display("FAIL abort_done: got %0d done, required 1 (from restart only)", done_cnt); end
    endtask

    task automatic test_ignored_inputs();
        clear_stats();
        tx_delay = 10; tx_auto = 1'b1;
        start_stream(13'h0040, 3);
        // now in FETCH: spurious tx_done plus a second start
        manual_done = 1'b1; start = 1'b1; start_addr = 13'h0100; byte_cnt = 14'd7;
        @(posedge clk); #1;
        manual_done = 1'b0; start = 1'b0;
        wait_sent("ignored_first", 1, 20);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("ignored", 200);
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (sent != 3 || exp_q.size() != 0 || done_cnt != 1) begin
            errors++; $display("FAIL ignored_stream: got sent=%0d done=%0d, required 3 and 1", sent, done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        clear_stats();
        tx_delay = 30; tx_auto = 1'b1;
        start_stream(13'h0050, 3);
        wait_sent("rst_first", 1, 20);
        repeat (5) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checks = checks + 1;
        if ({rd_addr, tx_data, send_en, busy, done, aborted, state} !== '0) begin
            errors++;
            $display("FAIL reset_async: got rd_addr=%h tx_data=%h busy=%b state=%0d, required all 0", rd_addr, tx_data, busy, state);
        end
        tx_pending = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        clear_stats();
        tx_delay = 5;
        start_stream(13'h0060, 1);
        wait_done("rst_restart", 100);
        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (sent != 1 || exp_q.size() != 0 || done_cnt != 1 || abort_cnt != 0) begin
            errors++; $display("FAIL reset_restart: got sent=%0d done=%0d aborted=%0d, required 1 1 0", sent, done_cnt, abort_cnt);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            int n;
            logic [ADDR_W-1:0] a;
            clear_stats();
            n = $urandom_range(1, 6);
            a = ADDR_W'($urandom_range(0, 8191));
            tx_delay = $urandom_range(1, 8);
            start_stream(a, n);
            wait_done("b2b", 200);
            checks = checks + 1;
            if (sent != n || exp_q.size() != 0) begin
                errors++; $display("FAIL b2b_count: got %0d send_en, required %0d", sent, n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_zero_len();
        test_abort();
        test_ignored_inputs();
        test_reset_mid();
        test_back_to_back();
        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
